// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frontend
// Description : Asynchronous-serial receiver with 16x oversampling, mid-bit
//               sampling, false-start rejection, optional parity, and framing,
//               parity and overrun detection. Received bytes are handed off
//               over a valid/ready interface.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-low reset
//               RX           - serial line, idle high, asynchronous to clk
//               data_out     - received byte, LSB first on the line
//               rx_valid     - data_out and error flags hold a byte
//               rx_ready     - consumer accepts when rx_valid && rx_ready
//               frame_error  - stop bit was low (qualified by rx_valid)
//               parity_error - parity mismatch (qualified by rx_valid)
//               overrun      - one-cycle pulse, a completed byte was dropped
//               rx_busy      - receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] data_out,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       parity_error,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int             c_DIV     = CLK_FREQ / (16 * BAUD_RATE);
    localparam int             c_CW      = $clog2(c_DIV);
    localparam logic [c_CW-1:0] c_DIV_MAX = c_CW'(c_DIV - 1);
    localparam logic           c_ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [c_CW-1:0] r_div;
    logic [3:0]      r_smp;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_par_err;
    logic            w_tick;
    logic            w_bit_pt;
    logic            w_stop_pt;
    logic            w_can_deliver;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_fe;
    logic            r_pe;
    logic            r_ovr;

    // Two-flop synchronizer; resets to the idle-line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], RX};
    end
    assign w_rx_s = r_sync[1];

    assign w_tick    = (r_div == c_DIV_MAX);
    assign w_bit_pt  = w_tick && (r_smp == 4'hF);
    assign w_stop_pt = (r_state == STOP) && w_bit_pt;
    // A byte may land if the holding register is empty or is being drained
    // in this very cycle.
    assign w_can_deliver = !r_valid || rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (!w_rx_s) w_state_nxt = START;
            START:     if (w_tick && (r_smp == 4'd7))
                           w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:      if (w_bit_pt && (r_bit == 3'd7))
                           w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:    if (w_bit_pt) w_state_nxt = STOP;
            // A low stop bit with the line still low is a break: wait for
            // the line to recover before hunting for the next start bit.
            STOP:      if (w_bit_pt) w_state_nxt = w_rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (w_rx_s) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Baud tick divider, realigned to the detected start edge so that the
    // 8th tick lands in the middle of the start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                r_div <= '0;
        else if ((r_state == IDLE) && !w_rx_s)   r_div <= '0;
        else if (w_tick)                         r_div <= '0;
        else                                     r_div <= r_div + 1'b1;
    end

    // Sample counter; cleared at mid-start so later samples fall mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                           r_smp <= 4'd0;
        else if (r_state == IDLE)                           r_smp <= 4'd0;
        else if ((r_state == START) && w_tick && (r_smp == 4'd7)) r_smp <= 4'd0;
        else if (w_tick)                                    r_smp <= r_smp + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_par_err <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_bit     <= 3'd0;
                r_par_err <= 1'b0;
            end else if ((r_state == DATA) && w_bit_pt) begin
                r_shift[r_bit] <= w_rx_s;
                r_bit          <= r_bit + 3'd1;
            end else if ((r_state == PARITY) && w_bit_pt) begin
                r_par_err <= (^r_shift) ^ w_rx_s ^ c_ODD;
            end
        end
    end

    // Output holding register and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_pe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_stop_pt && w_can_deliver) begin
                r_data  <= r_shift;
                r_fe    <= ~w_rx_s;
                r_pe    <= r_par_err;
                r_valid <= 1'b1;
            end else begin
                if (w_stop_pt) r_ovr <= 1'b1;
                if (r_valid && rx_ready) r_valid <= 1'b0;
            end
        end
    end

    assign data_out     = r_data;
    assign rx_valid     = r_valid;
    assign frame_error  = r_fe;
    assign parity_error = r_pe;
    assign overrun      = r_ovr;
    assign rx_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_frontend
// Description : Scoreboard bench for uart_rx_frontend. A parity-enabled
//               instance and a parity-disabled instance share the clock and
//               reset; each has its own serial line and expected-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;

    localparam int c_BIT = 64;   // clk per bit with DIV=4

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       RX_np;
    logic       rx_ready;
    logic       rx_ready_np;
    logic [7:0] data_out,  data_out_np;
    logic       rx_valid,  rx_valid_np;
    logic       frame_error, frame_error_np;
    logic       parity_error, parity_error_np;
    logic       overrun, overrun_np;
    logic       rx_busy, rx_busy_np;

    exp_t q_main[$];
    exp_t q_np[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_ovr    = 0;
    int   n_ovr_np = 0;

    always #5 clk = ~clk;

    uart_rx_frontend #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(25_000), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .RX(RX), .data_out(data_out), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_error(frame_error), .parity_error(parity_error),
        .overrun(overrun), .rx_busy(rx_busy)
    );

    uart_rx_frontend #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(25_000), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut_np (
        .clk(clk), .rst(rst), .RX(RX_np), .data_out(data_out_np), .rx_valid(rx_valid_np),
        .rx_ready(rx_ready_np), .frame_error(frame_error_np), .parity_error(parity_error_np),
        .overrun(overrun_np), .rx_busy(rx_busy_np)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: compare against the scoreboard on every accepted byte.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst && rx_valid && rx_ready) begin
            n_acc++;
            if (q_main.size() == 0) begin
                chk("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                e = q_main.pop_front();
                chk("data_out", {24'h0, data_out}, {24'h0, e.d});
                chk("frame_error", {31'h0, frame_error}, {31'h0, e.fe});
                chk("parity_error", {31'h0, parity_error}, {31'h0, e.pe});
            end
        end
        if (overrun) n_ovr++;
    end

    always @(negedge clk) begin : mon_np
        exp_t e;
        if (rst && rx_valid_np && rx_ready_np) begin
            if (q_np.size() == 0) begin
                chk("np_unexpected_byte", {24'h0, data_out_np}, 32'hFFFF_FFFF);
            end else begin
                e = q_np.pop_front();
                chk("np_data_out", {24'h0, data_out_np}, {24'h0, e.d});
                chk("np_frame_error", {31'h0, frame_error_np}, {31'h0, e.fe});
                chk("np_parity_error", {31'h0, parity_error_np}, {31'h0, e.pe});
            end
        end
        if (overrun_np) n_ovr_np++;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) RX = v;
        else            RX_np = v;
    endtask

    // Drives one frame; abort_bit >= 0 stops halfway through that data bit.
    task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                              input bit has_par, input logic stopv,
                              input int abort_bit, input bit check_lat);
        set_line(which, 1'b0);
        for (int k = 1; k <= c_BIT; k++) begin
            @(posedge clk);
            #1;
            if (check_lat && k == 2) chk("busy_lat_2clk", {31'h0, rx_busy}, 32'h0);
            if (check_lat && k == 3) chk("busy_lat_3clk", {31'h0, rx_busy}, 32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            if (i == abort_bit) begin
                tick_n(c_BIT / 2);
                return;
            end
            tick_n(c_BIT);
        end
        if (has_par) begin
            set_line(which, pbit);
            tick_n(c_BIT);
        end
        set_line(which, stopv);
        tick_n(c_BIT);
    endtask

    initial begin : stim
        int acc0;
        int ovr0;
        rst         = 1'b0;
        RX          = 1'b1;
        RX_np       = 1'b1;
        rx_ready    = 1'b1;
        rx_ready_np = 1'b1;
        tick_n(5);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_frame_error", {31'h0, frame_error}, 32'h0);
        chk("rst_parity_error", {31'h0, parity_error}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_rx_busy", {31'h0, rx_busy}, 32'h0);
        rst = 1'b1;
        tick_n(20);

        // Clean frame A5, even parity bit 0.
        q_main.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 1'b1);
        tick_n(20);
        chk("clean_overrun_count", n_ovr, 32'd0);

        // Glitch: 20 clk low is rejected at the mid-start sample.
        acc0 = n_acc;
        RX = 1'b0;
        tick_n(20);
        chk("glitch_busy_high", {31'h0, rx_busy}, 32'h1);
        RX = 1'b1;
        tick_n(40);
        chk("glitch_busy_low", {31'h0, rx_busy}, 32'h0);
        chk("glitch_no_valid", n_acc - acc0, 32'd0);
        tick_n(30);

        // Parity error: 3C has four ones, parity bit 1 is wrong in even mode.
        q_main.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b1});
        send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        tick_n(20);

        // Parity disabled instance.
        q_np.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
        send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        tick_n(20);

        // Break: stop bit 0 then line held low.
        q_main.push_back('{d: 8'h55, fe: 1'b1, pe: 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        tick_n(500);
        chk("break_busy_held", {31'h0, rx_busy}, 32'h1);
        RX = 1'b1;
        tick_n(6);
        chk("break_busy_released", {31'h0, rx_busy}, 32'h0);
        q_main.push_back('{d: 8'h12, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        tick_n(20);

        // Overrun: second byte dropped while the first is held.
        rx_ready = 1'b0;
        ovr0 = n_ovr;
        q_main.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        tick_n(10);
        chk("overrun_pulse_cycles", n_ovr - ovr0, 32'd1);
        chk("overrun_data_kept", {24'h0, data_out}, 32'h11);
        chk("overrun_valid_held", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        tick_n(1);
        chk("overrun_valid_drop", {31'h0, rx_valid}, 32'h0);
        tick_n(20);

        // Reset during data bit 4 of F0.
        send_frame(0, 8'hF0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        chk("midframe_busy", {31'h0, rx_busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_data_out", {24'h0, data_out}, 32'h0);
        chk("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("midrst_frame_error", {31'h0, frame_error}, 32'h0);
        chk("midrst_parity_error", {31'h0, parity_error}, 32'h0);
        chk("midrst_overrun", {31'h0, overrun}, 32'h0);
        chk("midrst_rx_busy", {31'h0, rx_busy}, 32'h0);
        RX = 1'b1;
        tick_n(5);
        rst = 1'b1;
        tick_n(100);
        q_main.push_back('{d: 8'h0F, fe: 1'b0, pe: 1'b0});
        send_frame(0, 8'h0F, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        tick_n(100);

        chk("main_queue_drained", q_main.size(), 32'd0);
        chk("np_queue_drained", q_np.size(), 32'd0);
        chk("total_overruns", n_ovr, 32'd1);
        chk("np_overruns", n_ovr_np, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
